// File: rtl/seven_scan_if.sv
// Display-scan bus: BCD word and controls in, one multiplexed digit out.
// The master drives the word and controls; the slave (seven_scan) drives the digit.
interface seven_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  blank_lz;
    logic [3:0]            bcd;
    logic [DIGITS-1:0]     an;
    logic                  blank;
    logic                  frame;
    logic                  err;

    modport master (
        output load, value, blank_lz,
        input  bcd, an, blank, frame, err
    );

    modport slave (
        input  load, value, blank_lz,
        output bcd, an, blank, frame, err
    );
endinterface

// File: rtl/seven_scan.sv
// Time-multiplexes a packed BCD word onto one shared digit bus with active-low
// enables, leading-zero blanking, invalid-code suppression and a frame pulse.
module seven_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst,
    seven_scan_if.slave  bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow;
    logic [CNT_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    next_idx;
    logic                advance;

    logic [3:0]          nib;
    logic                upper_zero;
    logic                invalid;
    logic [3:0]          bcd_d;
    logic [DIGITS-1:0]   an_d;
    logic                blank_d;

    assign advance  = (div_cnt == CNT_LAST);
    assign next_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // Everything is evaluated for the slot about to start, from the shadow
    // contents before the edge, so a load never shows up mid-slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        nib        = 4'd0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == next_idx) nib = shadow[4*i +: 4];
            if (i >= int'(next_idx) && shadow[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        invalid = (nib > 4'd9);

        bcd_d          = nib;
        blank_d        = 1'b0;
        an_d           = '1;
        an_d[next_idx] = 1'b0;
        if (invalid || (bus.blank_lz && next_idx != '0 && upper_zero)) begin
            bcd_d   = 4'd0;
            blank_d = 1'b1;
            an_d    = '1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (rst) begin
            shadow    <= '0;
            div_cnt   <= '0;
            idx       <= '0;
            bus.bcd   <= 4'd0;
            bus.an    <= {{(DIGITS-1){1'b1}}, 1'b0};
            bus.blank <= 1'b0;
            bus.frame <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            if (bus.load) shadow <= bus.value;
            bus.frame <= 1'b0;
            if (advance) begin
                div_cnt   <= '0;
                idx       <= next_idx;
                bus.bcd   <= bcd_d;
                bus.an    <= an_d;
                bus.blank <= blank_d;
                bus.frame <= (idx == IDX_LAST);
                if (invalid) bus.err <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_scan.sv
// Directed bench for seven_scan: a REFRESH_DIV=4 instance for the scan features
// and a REFRESH_DIV=1 instance for the every-cycle advance case.
module tb_seven_scan;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seven_scan_if #(.DIGITS(4)) if_a ();
    seven_scan_if #(.DIGITS(4)) if_b ();

    seven_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    seven_scan #(.DIGITS(4), .REFRESH_DIV(1)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b));

    // Observed vectors are {an, bcd, blank, frame, err}.
    function automatic logic [10:0] obs_a();
        return {if_a.an, if_a.bcd, if_a.blank, if_a.frame, if_a.err};
    endfunction

    function automatic logic [10:0] obs_b();
        return {if_b.an, if_b.bcd, if_b.blank, if_b.frame, if_b.err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one full 4-cycle slot on dut_a, starting just after its advance
    // edge, and ends just after the next advance edge.
    task automatic expect_slot(input string name, input logic [3:0] e_an, input logic [3:0] e_bcd,
                               input logic e_blank, input logic e_frame, input logic e_err);
        logic [10:0] exp;
        exp = {e_an, e_bcd, e_blank, e_frame, e_err};
        checks++;
        if (obs_a() !== exp) begin
            errors++;
            $display("FAIL %s slot start: got an/bcd/blank/frame/err=%b, expected %b", name, obs_a(), exp);
        end
        exp[1] = 1'b0;
        for (int c = 1; c < 4; c++) begin
            step();
            checks++;
            if (obs_a() !== exp) begin
                errors++;
                $display("FAIL %s mid-slot cycle %0d: got %b, expected %b", name, c, obs_a(), exp);
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        if_a.load = 1'b0;
        if_a.value = 16'h0000;
        if_a.blank_lz = 1'b0;
        step();
        step();
        checks++;
        if (obs_a() !== {4'b1110, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %b, expected %b", obs_a(), {4'b1110, 4'd0, 3'b000});
        end
        rst_a = 1'b0;
    endtask

    task automatic test_scan();
        expect_slot("scan_d0", 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_slot("scan_d1", 4'b1101, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_slot("scan_d2", 4'b1011, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_slot("scan_d3", 4'b0111, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load();
        if_a.load = 1'b1;
        if_a.value = 16'h1234;
        if_a.blank_lz = 1'b0;
        expect_slot("load_old_d0", 4'b1110, 4'd0, 1'b0, 1'b1, 1'b0);
        if_a.load = 1'b0;
        expect_slot("load_d1", 4'b1101, 4'd3, 1'b0, 1'b0, 1'b0);
        expect_slot("load_d2", 4'b1011, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_slot("load_d3", 4'b0111, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_slot("load_d0", 4'b1110, 4'd4, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_leading_zero();
        if_a.load = 1'b1;
        if_a.value = 16'h0050;
        if_a.blank_lz = 1'b1;
        expect_slot("lz_old_d1", 4'b1101, 4'd3, 1'b0, 1'b0, 1'b0);
        if_a.load = 1'b0;
        expect_slot("lz_d2_blank", 4'b1111, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_slot("lz_d3_blank", 4'b1111, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_slot("lz_d0", 4'b1110, 4'd0, 1'b0, 1'b1, 1'b0);
        expect_slot("lz_d1", 4'b1101, 4'd5, 1'b0, 1'b0, 1'b0);
        // Disabling blanking mid-slot must wait for the next advance edge.
        if_a.blank_lz = 1'b0;
        expect_slot("nolz_d2_held", 4'b1111, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_slot("nolz_d3", 4'b0111, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_slot("nolz_d0", 4'b1110, 4'd0, 1'b0, 1'b1, 1'b0);
        expect_slot("nolz_d1", 4'b1101, 4'd5, 1'b0, 1'b0, 1'b0);
        expect_slot("nolz_d2", 4'b1011, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_all_zero();
        if_a.load = 1'b1;
        if_a.value = 16'h0000;
        if_a.blank_lz = 1'b1;
        expect_slot("zero_old_d3", 4'b0111, 4'd0, 1'b0, 1'b0, 1'b0);
        if_a.load = 1'b0;
        expect_slot("zero_d0_lit", 4'b1110, 4'd0, 1'b0, 1'b1, 1'b0);
        expect_slot("zero_d1", 4'b1111, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_slot("zero_d2", 4'b1111, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_slot("zero_d3", 4'b1111, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_invalid();
        if_a.load = 1'b1;
        if_a.value = 16'h1A23;
        if_a.blank_lz = 1'b0;
        expect_slot("inv_old_d0", 4'b1110, 4'd0, 1'b0, 1'b1, 1'b0);
        if_a.load = 1'b0;
        expect_slot("inv_d1", 4'b1101, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_slot("inv_d2", 4'b1111, 4'd0, 1'b1, 1'b0, 1'b1);
        expect_slot("inv_d3", 4'b0111, 4'd1, 1'b0, 1'b0, 1'b1);
        if_a.load = 1'b1;
        if_a.value = 16'h1111;
        expect_slot("err_sticky_d0", 4'b1110, 4'd3, 1'b0, 1'b1, 1'b1);
        if_a.load = 1'b0;
        expect_slot("err_sticky_d1", 4'b1101, 4'd1, 1'b0, 1'b0, 1'b1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        checks++;
        if (obs_a() !== {4'b1110, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL err_cleared_by_rst: got %b, expected %b", obs_a(), {4'b1110, 4'd0, 3'b000});
        end
        expect_slot("post_rst_full_slot", 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load_on_advance();
        for (int c = 0; c < 3; c++) step();
        if_a.load = 1'b1;
        if_a.value = 16'h9876;
        step();
        if_a.load = 1'b0;
        checks++;
        if (obs_a() !== {4'b1011, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_on_advance_old: got %b, expected %b", obs_a(), {4'b1011, 4'd0, 3'b000});
        end
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (obs_a() !== {4'b0111, 4'd9, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_on_advance_new: got %b, expected %b", obs_a(), {4'b0111, 4'd9, 3'b000});
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp_b [10];
        exp_b = '{
            {4'b1101, 4'd0, 1'b0, 1'b0, 1'b0},
            {4'b1111, 4'd0, 1'b1, 1'b0, 1'b1},
            {4'b0111, 4'd4, 1'b0, 1'b0, 1'b1},
            {4'b1110, 4'd1, 1'b0, 1'b1, 1'b1},
            {4'b1101, 4'd2, 1'b0, 1'b0, 1'b1},
            {4'b1111, 4'd0, 1'b1, 1'b0, 1'b1},
            {4'b0111, 4'd4, 1'b0, 1'b0, 1'b1},
            {4'b1110, 4'd1, 1'b0, 1'b1, 1'b1},
            {4'b1101, 4'd2, 1'b0, 1'b0, 1'b1},
            {4'b1111, 4'd0, 1'b1, 1'b0, 1'b1}
        };
        if_b.blank_lz = 1'b0;
        if_b.value = 16'h4B21;
        if_b.load = 1'b1;
        rst_b = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            if_b.load = 1'b0;
            checks++;
            if (obs_b() !== exp_b[e]) begin
                errors++;
                $display("FAIL div1_edge%0d: got %b, expected %b", e + 1, obs_b(), exp_b[e]);
            end
        end
        // Now inside the digit-2 slot: reset must restart at digit 0 with err clear.
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        checks++;
        if (obs_b() !== {4'b1110, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL div1_reset_mid_scan: got %b, expected %b", obs_b(), {4'b1110, 4'd0, 3'b000});
        end
        step();
        checks++;
        if (obs_b() !== {4'b1101, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL div1_shadow_cleared: got %b, expected %b", obs_b(), {4'b1101, 4'd0, 3'b000});
        end
    endtask

    initial begin
        if_b.load = 1'b0;
        if_b.value = 16'h0000;
        if_b.blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_load();
        test_leading_zero();
        test_all_zero();
        test_invalid();
        test_load_on_advance();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
